// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared constants, bank index type and bit-reverse helper for the FFT reorder stages
//   NBANKS      number of ping-pong banks
//   bank_t      bank index
//   bit_reverse reverses the low k bits of x; callers cast the result to their own K width
package bitrev_pkg;
   localparam int NBANKS = 2;
   localparam int MAX_K = 32;
   localparam int IW = $clog2(MAX_K);
   typedef logic bank_t;
   function automatic logic [MAX_K-1:0] bit_reverse(input logic [MAX_K-1:0] x, input int k);
      logic [MAX_K-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_K; i++)
         if (i < k) r[IW'(i)] = x[IW'(k - 1 - i)];
      return r;
   endfunction
endpackage

// File: rtl/bitrev_pp_mem.sv
// bitrev_pp_mem: two-bank sample store, one sync write port and one async read port
//   clk_i    clock
//   we_i     write enable
//   waddr_i  {bank, addr} write address
//   wdata_i  write data
//   raddr_i  {bank, addr} read address
//   rdata_o  read data (combinational)
module bitrev_pp_mem #(
   parameter int K  = 10,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [K:0]    waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [K:0]    raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem [2**(K+1)];
   always_ff @(posedge clk_i)
      if (we_i) mem[waddr_i] <= wdata_i;
   assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/bitrev_scatter.sv
// bitrev_scatter: natural-order input, bit-reversed-order output frame reorder buffer (ping-pong)
//   clk_i, rst_ni     clock, async active-low reset
//   valid_i/ready_o   write-side handshake, data_i natural-order sample
//   valid_o/ready_i   read-side handshake, data_o/last_o registered bit-reversed frame output
//   BITREV_SCATTER_LAST_CHK_EN adds last_i and frame_err_o (one-cycle pulse on misplaced last_i)
module bitrev_scatter
   import bitrev_pkg::*;
#(
   parameter int K  = 10,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] data_o,
   output logic          last_o
`ifdef BITREV_SCATTER_LAST_CHK_EN
   ,
   input  logic          last_i,
   output logic          frame_err_o
`endif
);
   bank_t             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [K-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [NBANKS-1:0] full_q, full_d;
   logic              valid_q, valid_d, last_q, last_d;
   logic [DW-1:0]     data_q, data_d, rdata;
   logic              wr_fire, wr_wrap, rd_en, rd_wrap, out_free;
   logic [K:0]        waddr, raddr;
   assign ready_o = ~full_q[wr_bank_q];
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;
   // writer scatters to the bit-reversed slot, reader sweeps linearly
   assign waddr = {wr_bank_q, K'(bit_reverse(MAX_K'(wr_cnt_q), K))};
   assign raddr = {rd_bank_q, rd_cnt_q};
   bitrev_pp_mem #(.K(K), .DW(DW)) u_mem (
      .clk_i   (clk_i),
      .we_i    (wr_fire),
      .waddr_i (waddr),
      .wdata_i (data_i),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );
   always_comb begin
      wr_fire   = valid_i & ready_o;
      wr_wrap   = &wr_cnt_q;
      rd_wrap   = &rd_cnt_q;
      out_free  = ~valid_q | ready_i;
      rd_en     = full_q[rd_bank_q] & out_free;
      wr_cnt_d  = wr_fire ? wr_cnt_q + K'(1) : wr_cnt_q;
      wr_bank_d = (wr_fire & wr_wrap) ? ~wr_bank_q : wr_bank_q;
      rd_cnt_d  = rd_en ? rd_cnt_q + K'(1) : rd_cnt_q;
      rd_bank_d = (rd_en & rd_wrap) ? ~rd_bank_q : rd_bank_q;
      // set and clear always hit different banks, so both may apply
      full_d = full_q;
      if (rd_en & rd_wrap) full_d[rd_bank_q] = 1'b0;
      if (wr_fire & wr_wrap) full_d[wr_bank_q] = 1'b1;
      valid_d = rd_en ? 1'b1 : out_free ? 1'b0 : valid_q;
      last_d  = rd_en ? rd_wrap : out_free ? 1'b0 : last_q;
      data_d  = rd_en ? rdata : data_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         full_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         data_q    <= '0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         full_q    <= full_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         data_q    <= data_d;
      end
`ifdef BITREV_SCATTER_LAST_CHK_EN
   logic frame_err_q, frame_err_d;
   assign frame_err_o = frame_err_q;
   always_comb frame_err_d = wr_fire & (last_i != wr_wrap);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) frame_err_q <= 1'b0;
      else frame_err_q <= frame_err_d;
`endif
endmodule
